// File: rtl/lildma_pkg.sv
// lildma shared definitions: FSM states, register map, status bits,
// Unibus cycle codes and timer sizing.
package lildma_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_GRANT,
        ST_SETUP,
        ST_MSYN,
        ST_HOLD,
        ST_UNSYN,
        ST_NEXT,
        ST_RELEASE
    } state_t;

    localparam logic [31:0] ID_WORD = 32'h4C44_1001;

    localparam logic [1:0] REG_ID   = 2'd0;
    localparam logic [1:0] REG_ADDR = 2'd1;
    localparam logic [1:0] REG_CNT  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CB_GO    = 31;
    localparam int CB_ABORT = 30;
    localparam int CB_OP    = 0;

    localparam int SB_BUSY  = 31;
    localparam int SB_DONE  = 30;
    localparam int SB_TMO   = 29;
    localparam int SB_MIS   = 28;
    localparam int SB_ABT   = 27;
    localparam int SB_OP    = 16;

    localparam logic [1:0] CYC_DATI = 2'b00;
    localparam logic [1:0] CYC_DATO = 2'b10;

    localparam int TMR_W = 16;

    // The timer load lands one clock after state entry and the expiry
    // test happens on the last clock, so a state lasting n clocks loads n-2.
    function automatic logic [TMR_W-1:0] tmr_preset(input int n);
        return TMR_W'(n - 2);
    endfunction

endpackage

// File: rtl/lildma_tmr.sv
// Loadable down-counter shared by the deskew and bus-timeout waits.
// Expiry is masked on the clock a load is pending.
module lildma_tmr
    import lildma_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] val,
    output logic             expired
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = !load && (cnt == '0);

endmodule

// File: rtl/lildma.sv
// ARM-programmed Unibus NPR master that fills or verifies a word range,
// holding bus mastership for the whole burst.
module lildma
    import lildma_pkg::*;
#(
    parameter int DESKEW  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        armwrite,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        init_in_h,
    input  logic        npg_in_h,
    input  logic        ssyn_in_h,
    input  logic [15:0] d_in_h,
    output logic        npr_out_h,
    output logic        bbsy_out_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    output logic        msyn_out_h
);

    localparam logic [TMR_W-1:0] DSK = tmr_preset(DESKEW);
    localparam logic [TMR_W-1:0] TMO = tmr_preset(TIMEOUT);

    state_t           state;
    logic [16:0]      addr;
    logic [16:0]      addr_inc;
    logic [15:0]      count;
    logic [15:0]      pattern;
    logic [15:0]      lastdata;
    logic             op;
    logic             done;
    logic             tmo;
    logic             mis;
    logic             aborted;
    logic             abort_pend;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             expired;
    logic             wr_ctrl;
    logic             go_wr;
    logic             abort_wr;
    logic             abort_now;
    logic             busy;

    lildma_tmr u_tmr (
        .clk     (CLOCK),
        .rst_n   (RESET_N),
        .load    (tmr_load),
        .val     (tmr_val),
        .expired (expired)
    );

    assign addr_inc  = addr + 17'd1;
    assign busy      = (state != ST_IDLE);
    assign wr_ctrl   = armwrite && (armwaddr == REG_CTRL);
    assign abort_wr  = wr_ctrl && armwdata[CB_ABORT];
    assign go_wr     = wr_ctrl && armwdata[CB_GO] && !armwdata[CB_ABORT];
    assign abort_now = abort_wr || abort_pend;

    always_comb begin
        armrdata = '0;
        unique case (armraddr)
            REG_ID:   armrdata = ID_WORD;
            REG_ADDR: armrdata = {14'b0, addr, 1'b0};
            REG_CNT:  armrdata = {pattern, count};
            REG_CTRL: begin
                armrdata[SB_BUSY] = busy;
                armrdata[SB_DONE] = done;
                armrdata[SB_TMO]  = tmo;
                armrdata[SB_MIS]  = mis;
                armrdata[SB_ABT]  = aborted;
                armrdata[SB_OP]   = op;
                armrdata[15:0]    = lastdata;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            addr       <= '0;
            count      <= '0;
            pattern    <= '0;
            lastdata   <= '0;
            op         <= 1'b0;
            done       <= 1'b0;
            tmo        <= 1'b0;
            mis        <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            tmr_load   <= 1'b0;
            tmr_val    <= '0;
            npr_out_h  <= 1'b0;
            bbsy_out_h <= 1'b0;
            a_out_h    <= '0;
            c_out_h    <= CYC_DATI;
            d_out_h    <= '0;
            msyn_out_h <= 1'b0;
        end else begin
            tmr_load <= 1'b0;
            if (!busy && armwrite && armwaddr == REG_ADDR)
                addr <= armwdata[17:1];
            if (!busy && armwrite && armwaddr == REG_CNT) begin
                pattern <= armwdata[31:16];
                count   <= armwdata[15:0];
            end
            if (abort_wr && busy) begin
                abort_pend <= 1'b1;
                aborted    <= 1'b1;
            end
            if (init_in_h) begin
                state      <= ST_IDLE;
                abort_pend <= 1'b0;
                npr_out_h  <= 1'b0;
                bbsy_out_h <= 1'b0;
                a_out_h    <= '0;
                c_out_h    <= CYC_DATI;
                d_out_h    <= '0;
                msyn_out_h <= 1'b0;
                if (busy)
                    aborted <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        abort_pend <= 1'b0;
                        if (go_wr) begin
                            done    <= 1'b0;
                            tmo     <= 1'b0;
                            mis     <= 1'b0;
                            aborted <= 1'b0;
                            op      <= armwdata[CB_OP];
                            if (count == '0) begin
                                done <= 1'b1;
                            end else begin
                                npr_out_h <= 1'b1;
                                tmr_load  <= 1'b1;
                                tmr_val   <= TMO;
                                state     <= ST_REQ;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (abort_now) begin
                            npr_out_h <= 1'b0;
                            state     <= ST_RELEASE;
                        end else if (npg_in_h) begin
                            npr_out_h <= 1'b0;
                            state     <= ST_GRANT;
                        end else if (expired) begin
                            npr_out_h <= 1'b0;
                            tmo       <= 1'b1;
                            state     <= ST_RELEASE;
                        end
                    end
                    ST_GRANT: begin
                        bbsy_out_h <= 1'b1;
                        if (abort_now) begin
                            state <= ST_RELEASE;
                        end else begin
                            a_out_h  <= {addr, 1'b0};
                            c_out_h  <= op ? CYC_DATI : CYC_DATO;
                            d_out_h  <= op ? 16'h0 : pattern;
                            tmr_load <= 1'b1;
                            tmr_val  <= DSK;
                            state    <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        if (abort_now) begin
                            state <= ST_RELEASE;
                        end else if (expired) begin
                            msyn_out_h <= 1'b1;
                            tmr_load   <= 1'b1;
                            tmr_val    <= TMO;
                            state      <= ST_MSYN;
                        end
                    end
                    ST_MSYN: begin
                        if (ssyn_in_h) begin
                            if (op)
                                lastdata <= d_in_h;
                            tmr_load <= 1'b1;
                            tmr_val  <= DSK;
                            state    <= ST_HOLD;
                        end else if (expired) begin
                            msyn_out_h <= 1'b0;
                            tmo        <= 1'b1;
                            state      <= ST_RELEASE;
                        end
                    end
                    ST_HOLD: begin
                        if (expired) begin
                            msyn_out_h <= 1'b0;
                            d_out_h    <= '0;
                            state      <= ST_UNSYN;
                        end
                    end
                    ST_UNSYN: begin
                        if (!ssyn_in_h)
                            state <= abort_now ? ST_RELEASE : ST_NEXT;
                    end
                    ST_NEXT: begin
                        if (abort_now) begin
                            state <= ST_RELEASE;
                        end else if (op && lastdata != pattern) begin
                            mis   <= 1'b1;
                            state <= ST_RELEASE;
                        end else begin
                            addr  <= addr_inc;
                            count <= count - 16'd1;
                            if (count == 16'd1) begin
                                state <= ST_RELEASE;
                            end else begin
                                a_out_h  <= {addr_inc, 1'b0};
                                c_out_h  <= op ? CYC_DATI : CYC_DATO;
                                d_out_h  <= op ? 16'h0 : pattern;
                                tmr_load <= 1'b1;
                                tmr_val  <= DSK;
                                state    <= ST_SETUP;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        npr_out_h  <= 1'b0;
                        bbsy_out_h <= 1'b0;
                        msyn_out_h <= 1'b0;
                        a_out_h    <= '0;
                        c_out_h    <= CYC_DATI;
                        d_out_h    <= '0;
                        done       <= 1'b1;
                        abort_pend <= 1'b0;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lildma.sv
// Bench for lildma with a two-bank Unibus memory slave and an NPR
// arbiter that grants five clocks after the request.
module tb_lildma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        armwrite = 1'b0;
    logic [1:0]  armraddr = 2'd0;
    logic [1:0]  armwaddr = 2'd0;
    logic [31:0] armwdata = '0;
    logic [31:0] armrdata;
    logic        init = 1'b0;
    logic        npg;
    logic        ssyn;
    logic [15:0] d_in;
    logic        npr;
    logic        bbsy;
    logic [17:0] a_out;
    logic [1:0]  c_out;
    logic [15:0] d_out;
    logic        msyn;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lildma dut (
        .CLOCK      (clk),
        .RESET_N    (rst_n),
        .armwrite   (armwrite),
        .armraddr   (armraddr),
        .armwaddr   (armwaddr),
        .armwdata   (armwdata),
        .armrdata   (armrdata),
        .init_in_h  (init),
        .npg_in_h   (npg),
        .ssyn_in_h  (ssyn),
        .d_in_h     (d_in),
        .npr_out_h  (npr),
        .bbsy_out_h (bbsy),
        .a_out_h    (a_out),
        .c_out_h    (c_out),
        .d_out_h    (d_out),
        .msyn_out_h (msyn)
    );

    // Arbiter
    int arb_cnt = 0;
    always @(posedge clk) begin
        if (!npr) begin
            arb_cnt <= 0;
            npg     <= 1'b0;
        end else if (arb_cnt == 4) begin
            npg <= 1'b1;
        end else begin
            arb_cnt <= arb_cnt + 1;
        end
    end

    // Memory slave: bank 0 at 000000, bank 7 at 770000
    logic [15:0] mem0 [2048];
    logic [15:0] mem7 [2048];
    logic        poke = 1'b0;
    logic [10:0] poke_idx = '0;
    logic [15:0] poke_val = '0;
    int          sl_dly = 0;
    logic        hit0;
    logic        hit7;
    assign hit0 = (a_out[17:12] == 6'o00);
    assign hit7 = (a_out[17:12] == 6'o77);

    initial begin
        ssyn = 1'b0;
        d_in = '0;
        npg  = 1'b0;
    end

    always @(posedge clk) begin
        if (poke)
            mem0[poke_idx] <= poke_val;
        if (msyn && (hit0 || hit7)) begin
            sl_dly <= sl_dly + 1;
            if (sl_dly == 2 && !ssyn) begin
                ssyn <= 1'b1;
                if (c_out == 2'b10) begin
                    if (hit0) mem0[a_out[11:1]] <= d_out;
                    else      mem7[a_out[11:1]] <= d_out;
                end else begin
                    d_in <= hit0 ? mem0[a_out[11:1]] : mem7[a_out[11:1]];
                end
            end
        end else begin
            sl_dly <= 0;
            ssyn   <= 1'b0;
        end
    end

    // Bus monitor, cumulative counters
    logic        msyn_q = 1'b0;
    logic        npr_q = 1'b0;
    int          dato_n = 0;
    int          dati_n = 0;
    int          msyn_hi = 0;
    int          npr_n = 0;
    logic [17:0] last_a = '0;
    logic [17:0] prev_a = '0;
    always @(posedge clk) begin
        msyn_q <= msyn;
        npr_q  <= npr;
        if (msyn && !msyn_q) begin
            if (c_out == 2'b10) dato_n <= dato_n + 1;
            else                dati_n <= dati_n + 1;
            last_a <= a_out;
            prev_a <= last_a;
        end
        if (msyn)
            msyn_hi <= msyn_hi + 1;
        if (npr && !npr_q)
            npr_n <= npr_n + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic arm_wr(input logic [1:0] ra, input logic [31:0] wd);
        @(negedge clk);
        armwrite = 1'b1;
        armwaddr = ra;
        armwdata = wd;
        @(negedge clk);
        armwrite = 1'b0;
        armwdata = '0;
    endtask

    task automatic arm_rd(input logic [1:0] ra, output logic [31:0] rd);
        armraddr = ra;
        #1;
        rd = armrdata;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] ra,
                          input logic [31:0] exp);
        logic [31:0] v;
        arm_rd(ra, v);
        chk(nm, v, exp);
    endtask

    task automatic wait_done(input string nm, input int budget);
        logic [31:0] v;
        int n;
        n = 0;
        arm_rd(2'd3, v);
        while (!v[30] && n < budget) begin
            @(negedge clk);
            arm_rd(2'd3, v);
            n++;
        end
        checks++;
        if (!v[30]) begin
            failures++;
            $display("FAIL %s: done not seen in %0d clocks, status %h",
                     nm, budget, v);
        end
    endtask

    task automatic wait_msyn(input string nm, input int budget);
        int n;
        n = 0;
        while (!msyn && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!msyn) begin
            failures++;
            $display("FAIL %s: msyn not seen in %0d clocks", nm, budget);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    localparam logic [15:0] PAT = 16'o123456;

    vec_t vecs [11];
    int   s_dato, s_dati, s_hi, s_npr;

    initial begin
        vecs[0]  = '{0, 2'd0, 32'h0,         2'd0, 32'h4C441001};
        vecs[1]  = '{0, 2'd0, 32'h0,         2'd1, 32'h0};
        vecs[2]  = '{0, 2'd0, 32'h0,         2'd2, 32'h0};
        vecs[3]  = '{0, 2'd0, 32'h0,         2'd3, 32'h0};
        vecs[4]  = '{1, 2'd1, 32'h0003FFFF,  2'd1, 32'h0003FFFE};
        vecs[5]  = '{1, 2'd1, 32'hFFFF0041,  2'd1, 32'h00030040};
        vecs[6]  = '{1, 2'd2, 32'h12345678,  2'd2, 32'h12345678};
        vecs[7]  = '{1, 2'd0, 32'hFFFFFFFF,  2'd0, 32'h4C441001};
        vecs[8]  = '{1, 2'd3, 32'h40000000,  2'd3, 32'h0};
        vecs[9]  = '{1, 2'd3, 32'hC0000001,  2'd3, 32'h0};
        vecs[10] = '{1, 2'd2, 32'h0,         2'd2, 32'h0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_bus", {12'b0, npr, bbsy, msyn, c_out, 16'b0, 1'b0},
            32'h0);
        chk("reset_addr", {14'b0, a_out}, 32'h0);
        chk("reset_dout", {16'b0, d_out}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr)
                arm_wr(vecs[i].waddr, vecs[i].wdata);
            rd_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end
        repeat (20) @(negedge clk);
        chk("vec_no_npr", npr_n, 0);

        // Fill 000100..000106
        s_dato = dato_n; s_dati = dati_n;
        arm_wr(2'd1, 32'o100);
        arm_wr(2'd2, {PAT, 16'd4});
        arm_wr(2'd3, 32'h80000000);
        wait_done("fill_done", 2000);
        chk("fill_m100", mem0[32], PAT);
        chk("fill_m102", mem0[33], PAT);
        chk("fill_m104", mem0[34], PAT);
        chk("fill_m106", mem0[35], PAT);
        rd_chk("fill_addr", 2'd1, 32'o110);
        rd_chk("fill_cnt", 2'd2, {PAT, 16'd0});
        rd_chk("fill_stat", 2'd3, 32'h40000000);
        chk("fill_dato", dato_n - s_dato, 4);
        chk("fill_dati", dati_n - s_dati, 0);
        chk("fill_idle", {29'b0, npr, bbsy, msyn}, 32'h0);

        // Verify with word 104 cleared
        @(negedge clk);
        poke_idx = 11'd34; poke_val = 16'h0; poke = 1'b1;
        @(negedge clk);
        poke = 1'b0;
        s_dati = dati_n;
        arm_wr(2'd1, 32'o100);
        arm_wr(2'd2, {PAT, 16'd4});
        arm_wr(2'd3, 32'h80000001);
        wait_done("ver_done", 2000);
        rd_chk("ver_stat", 2'd3, 32'h50010000);
        rd_chk("ver_addr", 2'd1, 32'o104);
        rd_chk("ver_cnt", 2'd2, {PAT, 16'd2});
        chk("ver_dati", dati_n - s_dati, 3);

        // Fill into empty space: MSYN timeout
        s_hi = msyn_hi;
        arm_wr(2'd1, 32'o010000);
        arm_wr(2'd2, {PAT, 16'd1});
        arm_wr(2'd3, 32'h80000000);
        wait_done("tmo_done", 3000);
        rd_chk("tmo_stat", 2'd3, 32'h60000000);
        rd_chk("tmo_cnt", 2'd2, {PAT, 16'd1});
        checks++;
        if (msyn_hi - s_hi < 995 || msyn_hi - s_hi > 1005) begin
            failures++;
            $display("FAIL tmo_len: msyn high %0d clocks, expected 1000",
                     msyn_hi - s_hi);
        end
        chk("tmo_idle", {29'b0, npr, bbsy, msyn}, 32'h0);

        // Zero count go
        arm_wr(2'd2, {PAT, 16'd0});
        s_npr = npr_n;
        arm_wr(2'd3, 32'h80000000);
        rd_chk("zero_stat", 2'd3, 32'h40000000);
        repeat (10) @(negedge clk);
        chk("zero_npr", npr_n - s_npr, 0);

        // Writes and go while busy are ignored
        arm_wr(2'd1, 32'o200);
        arm_wr(2'd2, {PAT, 16'd2});
        arm_wr(2'd3, 32'h80000000);
        arm_wr(2'd2, {PAT, 16'd7});
        arm_wr(2'd1, 32'o1000);
        arm_wr(2'd3, 32'h80000000);
        wait_done("busy_done", 2000);
        rd_chk("busy_cnt", 2'd2, {PAT, 16'd0});
        rd_chk("busy_addr", 2'd1, 32'o204);

        // Abort while MSYN asserted
        arm_wr(2'd1, 32'o300);
        arm_wr(2'd2, {PAT, 16'd3});
        arm_wr(2'd3, 32'h80000000);
        wait_msyn("abt_msyn", 200);
        arm_wr(2'd3, 32'h40000000);
        wait_done("abt_done", 2000);
        rd_chk("abt_stat", 2'd3, 32'h48000000);
        rd_chk("abt_addr", 2'd1, 32'o300);
        rd_chk("abt_cnt", 2'd2, {PAT, 16'd3});
        chk("abt_mem", mem0[96], PAT);
        chk("abt_ssyn", {31'b0, ssyn}, 32'h0);

        // INIT during SETUP
        begin
            int n;
            arm_wr(2'd1, 32'o400);
            arm_wr(2'd2, {PAT, 16'd2});
            arm_wr(2'd3, 32'h80000000);
            n = 0;
            while (!(bbsy && !msyn && a_out == 18'o400) && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("init_setup", {31'b0, bbsy}, 32'h1);
            init = 1'b1;
            @(negedge clk);
            init = 1'b0;
            chk("init_bus", {12'b0, npr, bbsy, msyn, c_out, d_out}, 32'h0);
            chk("init_a", {14'b0, a_out}, 32'h0);
            rd_chk("init_stat", 2'd3, 32'h08000000);
            rd_chk("init_addr", 2'd1, 32'o400);
        end

        // Address wrap 777776 -> 000000
        arm_wr(2'd1, 32'o777776);
        arm_wr(2'd2, {16'h5A5A, 16'd2});
        arm_wr(2'd3, 32'h80000000);
        wait_done("wrap_done", 2000);
        chk("wrap_m7", mem7[2047], 16'h5A5A);
        chk("wrap_m0", mem0[0], 16'h5A5A);
        chk("wrap_a1", prev_a, 18'o777776);
        chk("wrap_a2", last_a, 18'o000000);
        rd_chk("wrap_addr", 2'd1, 32'o2);
        rd_chk("wrap_stat", 2'd3, 32'h40000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
